// File: rtl/tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
//   Programmable enable-tick generator feeding the `en` input of the 8-bit
//   up-counter stage. Emits one-cycle o_en_out pulses every (div+1) cycles,
//   either free-running (burst length 0) or for a fixed number of pulses,
//   after which o_done pulses once and the block returns to idle.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   i_cfg_div    in   divisor N, tick period is N+1 cycles
//   i_cfg_burst  in   burst length M, 0 = free-running
//   i_cfg_valid  in   configuration offered
//   o_cfg_ready  out  configuration accepted (high only while idle)
//   i_start      in   begin generating ticks (level, sampled each edge)
//   i_stop       in   abort generation (level, sampled each edge)
//   o_en_out     out  registered one-cycle tick
//   o_busy       out  high while generating ticks
//   o_done       out  registered one-cycle pulse after a burst completes
// ---------------------------------------------------------------------------
module tick_prescaler #(
  parameter int DIV_WIDTH   = 8,
  parameter int BURST_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DIV_WIDTH-1:0]   i_cfg_div,
  input  logic [BURST_WIDTH-1:0] i_cfg_burst,
  input  logic                   i_cfg_valid,
  output logic                   o_cfg_ready,
  input  logic                   i_start,
  input  logic                   i_stop,
  output logic                   o_en_out,
  output logic                   o_busy,
  output logic                   o_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam logic [BURST_WIDTH-1:0] BURST_ONE  = BURST_WIDTH'(1);
  localparam logic [BURST_WIDTH-1:0] BURST_ZERO = '0;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [DIV_WIDTH-1:0]   r_div;
  logic [DIV_WIDTH-1:0]   w_div_next;
  logic [BURST_WIDTH-1:0] r_burst;
  logic [BURST_WIDTH-1:0] w_burst_next;
  logic [DIV_WIDTH-1:0]   r_pre_cnt;
  logic [DIV_WIDTH-1:0]   w_pre_cnt_next;
  logic [BURST_WIDTH-1:0] r_pulse_cnt;
  logic [BURST_WIDTH-1:0] w_pulse_cnt_next;
  logic                   r_en_out;
  logic                   w_en_out_next;
  logic                   r_done;
  logic                   w_done_next;

  logic w_tick;
  logic w_last;
  logic w_go;

  // A tick is due when the prescaler has counted up to the divisor.
  assign w_tick = (r_pre_cnt == r_div);
  // The pulse about to be emitted is the final one of a finite burst.
  assign w_last = (r_burst != BURST_ZERO) && (r_pulse_cnt == (r_burst - BURST_ONE));
  // stop has priority over start when both are sampled high.
  assign w_go   = i_start && !i_stop;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_go) w_state_next = ST_RUN;
      ST_RUN: begin
        if (i_stop) begin
          w_state_next = ST_IDLE;
        end else if (w_tick && w_last) begin
          w_state_next = ST_FIN;
        end
      end
      ST_FIN:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath logic (next values for the registered outputs)
  // -------------------------------------------------------------------------
  always_comb begin
    w_div_next       = r_div;
    w_burst_next     = r_burst;
    w_pre_cnt_next   = r_pre_cnt;
    w_pulse_cnt_next = r_pulse_cnt;
    w_en_out_next    = 1'b0;
    w_done_next      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_cfg_valid) begin
          w_div_next   = i_cfg_div;
          w_burst_next = i_cfg_burst;
        end
        if (w_go) begin
          w_pre_cnt_next   = '0;
          w_pulse_cnt_next = '0;
        end
      end
      ST_RUN: begin
        if (i_stop) begin
          // Abort suppresses any tick that would have fired on this edge.
          w_pre_cnt_next   = '0;
          w_pulse_cnt_next = '0;
        end else if (w_tick) begin
          w_pre_cnt_next   = '0;
          w_en_out_next    = 1'b1;
          w_pulse_cnt_next = r_pulse_cnt + BURST_ONE;
        end else begin
          w_pre_cnt_next   = r_pre_cnt + DIV_WIDTH'(1);
        end
      end
      ST_FIN:  w_done_next = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div       <= '0;
      r_burst     <= '0;
      r_pre_cnt   <= '0;
      r_pulse_cnt <= '0;
      r_en_out    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_div       <= w_div_next;
      r_burst     <= w_burst_next;
      r_pre_cnt   <= w_pre_cnt_next;
      r_pulse_cnt <= w_pulse_cnt_next;
      r_en_out    <= w_en_out_next;
      r_done      <= w_done_next;
    end
  end

  assign o_cfg_ready = (r_state == ST_IDLE);
  assign o_busy      = (r_state == ST_RUN);
  assign o_en_out    = r_en_out;
  assign o_done      = r_done;

endmodule

// File: tb/tb_tick_prescaler.sv
module tb_tick_prescaler;

  logic       clk;
  logic       rst_n;
  logic [7:0] cfg_div;
  logic [7:0] cfg_burst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       start;
  logic       stop;
  logic       en_out;
  logic       busy;
  logic       done;

  tick_prescaler #(.DIV_WIDTH(8), .BURST_WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cfg_div   (cfg_div),
    .i_cfg_burst (cfg_burst),
    .i_cfg_valid (cfg_valid),
    .o_cfg_ready (cfg_ready),
    .i_start     (start),
    .i_stop      (stop),
    .o_en_out    (en_out),
    .o_busy      (busy),
    .o_done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string tag;
    logic  en;
    logic  bsy;
    logic  dn;
    logic  rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   tick_cnt = 0;   // models the downstream 8-bit counter

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard consumer: each entry describes the outputs after one edge.
  always @(negedge clk) begin
    if (en_out === 1'b1) tick_cnt++;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_val({e.tag, ".en"},   32'(en_out),    32'(e.en));
      check_val({e.tag, ".busy"}, 32'(busy),      32'(e.bsy));
      check_val({e.tag, ".done"}, 32'(done),      32'(e.dn));
      check_val({e.tag, ".rdy"},  32'(cfg_ready), 32'(e.rdy));
      $display("%s en=%0b busy=%0b done=%0b rdy=%0b", e.tag, en_out, busy, done, cfg_ready);
    end
  end

  function automatic exp_t expect_at(input string tag, input int n, input int m,
                                     input int c, input int stop_c);
    exp_t e;
    int   p;
    p     = n + 1;
    e.tag = $sformatf("%s[%0d]", tag, c);
    if (stop_c > 0 && c >= stop_c) begin
      e.en = 1'b0; e.bsy = 1'b0; e.dn = 1'b0; e.rdy = 1'b1;
    end else begin
      e.en  = ((c % p) == 0) && (c > 0) && (m == 0 || (c / p) <= m);
      e.bsy = (m == 0) || (c < m * p);
      e.dn  = (m != 0) && (c == m * p + 1);
      e.rdy = (m != 0) && (c > m * p);
    end
    return e;
  endfunction

  // Start a run (optionally loading config on the same edge) and follow it
  // for `cycles` further edges. stop is raised at edge stop_c (0 = never).
  // Edges dis_lo..dis_hi offer cfg div=7 and re-assert start while running.
  task automatic run_ticks(input string tag, input bit load, input int n, input int m,
                           input int cycles, input int stop_c,
                           input int dis_lo, input int dis_hi);
    cfg_valid = load;
    cfg_div   = 8'(n);
    cfg_burst = 8'(m);
    start     = 1'b1;
    stop      = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(expect_at(tag, n, m, 0, stop_c));
    cfg_valid = 1'b0;
    start     = 1'b0;
    for (int c = 1; c <= cycles; c++) begin
      stop = (c == stop_c);
      if (c >= dis_lo && c <= dis_hi) begin
        cfg_valid = 1'b1;
        cfg_div   = 8'd7;
        start     = 1'b1;
      end else begin
        cfg_valid = 1'b0;
        start     = 1'b0;
      end
      @(posedge clk); #1;
      exp_q.push_back(expect_at(tag, n, m, c, stop_c));
    end
    stop      = 1'b0;
    cfg_valid = 1'b0;
    start     = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_div   = '0;
    cfg_burst = '0;
    cfg_valid = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    #2;
    check_val("rst.en",   32'(en_out),    32'd0);
    check_val("rst.busy", 32'(busy),      32'd0);
    check_val("rst.done", 32'(done),      32'd0);
    check_val("rst.rdy",  32'(cfg_ready), 32'd1);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Free run, div=3; config/start offered during RUN must be ignored.
    run_ticks("free", 1'b1, 3, 0, 21, 21, 5, 9);
    // Burst of 5 pulses, 2 cycles apart.
    run_ticks("burst", 1'b1, 1, 5, 13, 0, 0, -1);
    // div=0 burst of 3: back-to-back ticks, counter advances 0->3.
    @(negedge clk); tick_cnt = 0;
    @(posedge clk); #1;
    run_ticks("div0", 1'b1, 0, 3, 6, 0, 0, -1);
    @(negedge clk); #1;
    check_val("div0.counter", 32'(tick_cnt), 32'd3);
    @(posedge clk); #1;
    // Stop on the edge where the second tick is due, then restart.
    run_ticks("stop", 1'b1, 2, 0, 6, 6, 0, -1);
    run_ticks("restart", 1'b0, 2, 0, 7, 7, 0, -1);

    // start and stop together in idle: stop wins.
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back('{tag: "startstop", en: 1'b0, bsy: 1'b0, dn: 1'b0, rdy: 1'b1});
    start = 1'b0; stop = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset mid-burst, between clock edges.
    run_ticks("prereset", 1'b1, 0, 10, 4, 0, 0, -1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_val("areset.en",   32'(en_out),    32'd0);
    check_val("areset.busy", 32'(busy),      32'd0);
    check_val("areset.done", 32'(done),      32'd0);
    check_val("areset.rdy",  32'(cfg_ready), 32'd1);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("postreset.rdy", 32'(cfg_ready), 32'd1);
    // Start without loading: div and burst were cleared, so ticks every cycle.
    run_ticks("postreset", 1'b0, 0, 0, 4, 4, 0, -1);

    repeat (3) @(posedge clk);
    #1;
    check_val("scoreboard.drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
